vending_machine_change: RTL
===========================

VENDING_MACHINE_CHANGE -- requirements
Module: vending_machine_change

Interface
REQ-001 SHALL have parameter PRICE, default 4, meaning item price in nickel units (1..16).
REQ-002 SHALL have parameter CREDIT_W, default 5, meaning width of credit and change counters; legal only if 2^CREDIT_W-1 >= PRICE+7.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port nickel  input  1  5-cent coin present this cycle.
REQ-006 SHALL have port dime  input  1  10-cent coin present this cycle.
REQ-007 SHALL have port quarter  input  1  25-cent coin present this cycle.
REQ-008 SHALL have port cancel  input  1  refund request.
REQ-009 SHALL have port dispense  output  1  item release, one-cycle pulse.
REQ-010 SHALL have port change_nickel  output  1  one nickel returned per asserted cycle.
REQ-011 SHALL have port coin_reject  output  1  coin(s) this cycle not accepted, returned to user.
REQ-012 SHALL have port credit  output  CREDIT_W  current accumulated credit, nickel units.

Function
REQ-013 SHALL implement states COLLECT, VEND, REFUND; dispense = (state==VEND); change_nickel = (state==REFUND).
REQ-014 Coin values SHALL be nickel=1, dime=2, quarter=5; coins asserted together in one cycle SHALL be summed (max 8).
REQ-015 In COLLECT, sum = credit + coin value; if sum >= PRICE: next state VEND, change register <= sum-PRICE, credit <= 0.
REQ-016 In COLLECT with sum < PRICE: credit <= sum, stay COLLECT.
REQ-017 VEND SHALL last exactly one cycle; next REFUND if change register > 0, else COLLECT.
REQ-018 REFUND SHALL assert change_nickel once per cycle and decrement change register; leave to COLLECT on the cycle the register goes 1 -> 0 (N nickels = N cycles).
REQ-019 coin_reject SHALL be combinational: any coin input asserted while state != COLLECT; rejected coins SHALL NOT affect credit or change.
REQ-020 Latency: dispense SHALL assert on the cycle after the edge that samples the completing coin.
REQ-021 Arithmetic SHALL be unsigned at CREDIT_W bits; with legal parameters no overflow occurs.
REQ-022 Any undefined state encoding SHALL return to COLLECT with credit and change cleared.

Reset
REQ-023 reset_n low SHALL immediately force state=COLLECT, credit=0, change register=0, independent of clock.
REQ-024 During and after reset: dispense=0, change_nickel=0, credit=0; coin_reject follows REQ-019 (0 in COLLECT).
REQ-025 Reset asserted mid-VEND or mid-REFUND SHALL abort it; no further dispense or change pulses.

Configuration
REQ-026 Macro VENDING_CANCEL_EN SHALL compile in refund-on-cancel.
REQ-027 With VENDING_CANCEL_EN: cancel in COLLECT with credit>0 and no coin SHALL load change <= credit, credit <= 0, next REFUND; cancel with a coin the same cycle SHALL be ignored (coin accepted per REQ-015/016); cancel outside COLLECT or with credit=0 SHALL be ignored.
REQ-028 Without VENDING_CANCEL_EN: cancel port SHALL exist but be ignored; credit is retained until purchase.

Verification (PRICE=4)
REQ-029 nickel on 4 separate cycles -> credit 1,2,3 then dispense one cycle after 4th coin, no change_nickel, credit=0.
REQ-030 single quarter -> dispense 1 cycle, then change_nickel 1 cycle, then COLLECT with credit=0.
REQ-031 dime+quarter same cycle (7) -> dispense, then exactly 3 change_nickel cycles.
REQ-032 dime then nickel (credit 3), cancel -> with VENDING_CANCEL_EN 3 change_nickel cycles, no dispense; without, credit stays 3.
REQ-033 nickel asserted during VEND and REFUND cycles -> coin_reject=1 those cycles, change count and credit unaffected.
REQ-034 quarter+dime (7) -> reset_n low during 2nd REFUND cycle -> all outputs 0 immediately, no further change_nickel after release.

Source files
------------

// File: rtl/vending_machine_change.sv
// vending_machine_change: coin-accumulating vending FSM that returns change one nickel per cycle.
// Define VENDING_CANCEL_EN to compile in refund-on-cancel; otherwise cancel is ignored.
module vending_machine_change #(
    parameter int PRICE    = 4,
    parameter int CREDIT_W = 5
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    input  logic                cancel,
    output logic                dispense,
    output logic                change_nickel,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit
);
    typedef enum logic [1:0] {COLLECT = 2'd0, VEND = 2'd1, REFUND = 2'd2} state_t;

    state_t              state, next_state;
    logic [CREDIT_W-1:0] change, next_change, next_credit, coin_val, sum;
    logic                any_coin, cancel_fire;

    assign any_coin = nickel | dime | quarter;
    assign coin_val = (quarter ? CREDIT_W'(5) : '0) + (dime ? CREDIT_W'(2) : '0)
                    + (nickel ? CREDIT_W'(1) : '0);
    assign sum      = credit + coin_val;

`ifdef VENDING_CANCEL_EN
    // a coin arriving with cancel wins, so the cancel is dropped that cycle
    assign cancel_fire = cancel && !any_coin && (credit != '0);
`else
    assign cancel_fire = cancel & 1'b0;
`endif

    always_comb begin
        next_state  = state;
        next_credit = credit;
        next_change = change;
        case (state)
            COLLECT: begin
                if (cancel_fire) begin
                    next_change = credit;
                    next_credit = '0;
                    next_state  = REFUND;
                end else if (sum >= CREDIT_W'(PRICE)) begin
                    next_change = sum - CREDIT_W'(PRICE);
                    next_credit = '0;
                    next_state  = VEND;
                end else begin
                    next_credit = sum;
                end
            end
            VEND:    next_state = (change != '0) ? REFUND : COLLECT;
            REFUND: begin
                next_change = (change != '0) ? change - CREDIT_W'(1) : '0;
                next_state  = (change <= CREDIT_W'(1)) ? COLLECT : REFUND;
            end
            default: begin
                next_state  = COLLECT;
                next_credit = '0;
                next_change = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= COLLECT;
            credit <= '0;
            change <= '0;
        end else begin
            state  <= next_state;
            credit <= next_credit;
            change <= next_change;
        end
    end

    assign dispense      = (state == VEND);
    assign change_nickel = (state == REFUND);
    assign coin_reject   = any_coin && (state != COLLECT);
endmodule
